// File: rtl/uart_tx_fifo_if.sv
// Producer-side bundle for uart_tx_fifo: word handshake plus line/status.
// master drives tx_data/tx_valid; slave drives tx_ready, tx, busy, fifo_count.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx;
  logic                 busy;
  logic [CW-1:0]        fifo_count;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx, busy, fifo_count
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx, busy, fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART serialiser with transmit FIFO; frames: start, data LSB first, opt parity, stop.
// Ports: clk, rst (async, active-high), bus (slave: tx_data/valid/ready, tx, busy, fifo_count).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int BDW = $clog2(CLKS_PER_BIT);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [BDW-1:0] BAUD_LAST = BDW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]  DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]  STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [CW-1:0]  FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_q, rd_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rdy_q;

  state_t               st_q, st_d;
  logic [BDW-1:0]       baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic push, pop, tick, nempty;

  assign push   = bus.tx_valid && rdy_q;
  assign nempty = (cnt_q != '0);
  assign tick   = (baud_q == BAUD_LAST);
  assign cnt_d  = cnt_q + CW'(push) - CW'(pop);

  // Ready is a flop fed from the next count, so it never sees tx_valid
  // combinationally and a same-cycle pop cannot raise it early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b1;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.tx_data;
  end

  always_comb begin
    st_d   = st_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    par_d  = par_q;
    tx_d   = tx_q;
    busy_d = busy_q;
    pop    = 1'b0;
    baud_d = (st_q == IDLE || tick) ? '0 : baud_q + BDW'(1);
    unique case (st_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        pop    = nempty;
      end
      START: begin
        if (tick) begin
          st_d  = DATA;
          bit_d = '0;
          tx_d  = sh_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              st_d = PARITY;
              tx_d = par_q;
            end else begin
              st_d = STOP;
              tx_d = 1'b1;
            end
          end else begin
            bit_d = bit_q + BW'(1);
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          st_d  = STOP;
          bit_d = '0;
          tx_d  = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_q == STOP_LAST) begin
            if (nempty) begin
              pop = 1'b1;
            end else begin
              st_d   = IDLE;
              busy_d = 1'b0;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: st_d = IDLE;
    endcase
    // Popping latches the word (and its parity) so later tx_data or
    // FIFO writes can never disturb the frame in flight.
    if (pop) begin
      st_d   = START;
      sh_d   = mem_q[rd_q];
      par_d  = (^mem_q[rd_q]) ^ (PARITY_ODD != 0);
      tx_d   = 1'b0;
      busy_d = 1'b1;
      baud_d = '0;
      bit_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      baud_q <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      par_q  <= 1'b0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      baud_q <= baud_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      par_q  <= par_d;
      tx_q   <= tx_d;
      busy_q <= busy_d;
    end
  end

  assign bus.tx_ready   = rdy_q;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_count = cnt_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1, even/odd parity, 7-bit 2-stop,
// FIFO back-to-back, simultaneous push/pop and mid-frame reset.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = '0;
  logic       vld = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifa ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifb ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifc ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) ifd ();

  assign ifa.tx_data  = data;
  assign ifa.tx_valid = vld;
  assign ifb.tx_data  = data;
  assign ifb.tx_valid = vld;
  assign ifc.tx_data  = data;
  assign ifc.tx_valid = vld;
  assign ifd.tx_data  = data[6:0];
  assign ifd.tx_valid = vld;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1),
    .PARITY_ODD(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_d (.clk(clk), .rst(rst), .bus(ifd));

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ifa.tx !== 1'b1) begin
      n_err++; $display("FAIL rst_tx got %b want 1", ifa.tx);
    end
    n_cmp++;
    if (ifa.busy !== 1'b0) begin
      n_err++; $display("FAIL rst_busy got %b want 0", ifa.busy);
    end
    n_cmp++;
    if (ifa.fifo_count !== 3'd0) begin
      n_err++; $display("FAIL rst_count got %0d want 0", ifa.fifo_count);
    end
    n_cmp++;
    if (ifa.tx_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_ready got %b want 1", ifa.tx_ready);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ifd.tx !== 1'b1 || ifd.busy !== 1'b0) begin
      n_err++; $display("FAIL rst_idle_d got tx=%b busy=%b want 1/0", ifd.tx, ifd.busy);
    end
  endtask

  task automatic test_8n1();
    logic [9:0] f;
    f = {1'b1, 8'hA5, 1'b0};
    do_reset();
    for (int c = 0; c <= 41; c++) begin
      @(negedge clk);
      vld  = (c == 0);
      data = 8'hA5;
      @(posedge clk);
      #1;
      if (c == 0) begin
        n_cmp++;
        if (ifa.tx !== 1'b1) begin
          n_err++; $display("FAIL 8n1_latency got %b want 1", ifa.tx);
        end
      end
      if (c >= 1 && c <= 40) begin
        n_cmp++;
        if (ifa.tx !== f[(c-1)/4]) begin
          n_err++; $display("FAIL 8n1_bit c=%0d got %b want %b", c, ifa.tx, f[(c-1)/4]);
        end
      end
      if (c == 40) begin
        n_cmp++;
        if (ifa.busy !== 1'b1) begin
          n_err++; $display("FAIL 8n1_busy_end got %b want 1", ifa.busy);
        end
      end
      if (c == 41) begin
        n_cmp++;
        if (ifa.busy !== 1'b0 || ifa.tx !== 1'b1) begin
          n_err++; $display("FAIL 8n1_idle got busy=%b tx=%b want 0/1", ifa.busy, ifa.tx);
        end
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0]  d;
    logic        pe, po;
    logic [10:0] fb, fc;
    for (int t = 0; t < 2; t++) begin
      d  = (t == 0) ? 8'h07 : 8'h00;
      pe = (t == 0) ? 1'b1 : 1'b0;
      po = (t == 0) ? 1'b0 : 1'b1;
      fb = {1'b1, pe, d, 1'b0};
      fc = {1'b1, po, d, 1'b0};
      do_reset();
      for (int c = 0; c <= 45; c++) begin
        @(negedge clk);
        vld  = (c == 0);
        data = d;
        @(posedge clk);
        #1;
        if (c >= 1 && c <= 44) begin
          n_cmp++;
          if (ifb.tx !== fb[(c-1)/4]) begin
            n_err++; $display("FAIL par_even d=%h c=%0d got %b want %b", d, c, ifb.tx, fb[(c-1)/4]);
          end
          n_cmp++;
          if (ifc.tx !== fc[(c-1)/4]) begin
            n_err++; $display("FAIL par_odd d=%h c=%0d got %b want %b", d, c, ifc.tx, fc[(c-1)/4]);
          end
        end
        if (c == 44) begin
          n_cmp++;
          if (ifb.busy !== 1'b1) begin
            n_err++; $display("FAIL par_busy_end got %b want 1", ifb.busy);
          end
        end
        if (c == 45) begin
          n_cmp++;
          if (ifb.busy !== 1'b0 || ifc.busy !== 1'b0) begin
            n_err++; $display("FAIL par_idle got b=%b c=%b want 0/0", ifb.busy, ifc.busy);
          end
        end
      end
    end
  endtask

  task automatic test_stop2();
    logic [9:0] f;
    f = {2'b11, 7'h55, 1'b0};
    do_reset();
    for (int c = 0; c <= 41; c++) begin
      @(negedge clk);
      vld  = (c == 0);
      data = 8'h55;
      @(posedge clk);
      #1;
      if (c >= 1 && c <= 40) begin
        n_cmp++;
        if (ifd.tx !== f[(c-1)/4]) begin
          n_err++; $display("FAIL stop2_bit c=%0d got %b want %b", c, ifd.tx, f[(c-1)/4]);
        end
      end
      if (c == 40) begin
        n_cmp++;
        if (ifd.busy !== 1'b1) begin
          n_err++; $display("FAIL stop2_busy_end got %b want 1", ifd.busy);
        end
      end
      if (c == 41) begin
        n_cmp++;
        if (ifd.busy !== 1'b0) begin
          n_err++; $display("FAIL stop2_idle got %b want 0", ifd.busy);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [6];
    int         acc [6];
    int         want [6];
    int         wi;
    logic       rdy;
    logic [9:0] f;
    w    = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    want = '{0, 1, 2, 3, 4, 42};
    acc  = '{-1, -1, -1, -1, -1, -1};
    wi   = 0;
    do_reset();
    for (int c = 0; c <= 241; c++) begin
      @(negedge clk);
      rdy = ifa.tx_ready;
      vld = (wi < 6);
      if (wi < 6) data = w[wi];
      @(posedge clk);
      if (vld && rdy) begin
        acc[wi] = c;
        wi++;
      end
      #1;
      if (c >= 1 && c <= 240) begin
        f = {1'b1, w[(c-1)/40], 1'b0};
        n_cmp++;
        if (ifa.tx !== f[((c-1)%40)/4]) begin
          n_err++; $display("FAIL b2b_bit c=%0d got %b want %b", c, ifa.tx, f[((c-1)%40)/4]);
        end
      end
      if (c == 4 || c == 42) begin
        n_cmp++;
        if (ifa.fifo_count !== 3'd4) begin
          n_err++; $display("FAIL b2b_count c=%0d got %0d want 4", c, ifa.fifo_count);
        end
      end
      if (c == 41) begin
        n_cmp++;
        if (ifa.fifo_count !== 3'd3) begin
          n_err++; $display("FAIL b2b_count_pop got %0d want 3", ifa.fifo_count);
        end
      end
      if (c == 240 || c == 241) begin
        n_cmp++;
        if (ifa.busy !== (c == 240)) begin
          n_err++; $display("FAIL b2b_busy c=%0d got %b want %b", c, ifa.busy, (c == 240));
        end
      end
    end
    vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (acc[i] !== want[i]) begin
        n_err++; $display("FAIL b2b_accept w%0d got cycle %0d want %0d", i, acc[i], want[i]);
      end
    end
  endtask

  task automatic test_simul_push_pop();
    logic [7:0] w [3];
    logic [9:0] f;
    logic       rdy;
    w = '{8'h3C, 8'hC3, 8'h81};
    do_reset();
    for (int c = 0; c <= 121; c++) begin
      @(negedge clk);
      rdy = ifa.tx_ready;
      vld = (c == 0 || c == 2 || c == 41);
      data = (c == 0) ? w[0] : (c == 2) ? w[1] : w[2];
      if (c == 41) begin
        n_cmp++;
        if (rdy !== 1'b1) begin
          n_err++; $display("FAIL sim_ready got %b want 1", rdy);
        end
      end
      @(posedge clk);
      #1;
      if (c >= 1 && c <= 120) begin
        f = {1'b1, w[(c-1)/40], 1'b0};
        n_cmp++;
        if (ifa.tx !== f[((c-1)%40)/4]) begin
          n_err++; $display("FAIL sim_bit c=%0d got %b want %b", c, ifa.tx, f[((c-1)%40)/4]);
        end
      end
      if (c == 40 || c == 41) begin
        n_cmp++;
        if (ifa.fifo_count !== 3'd1) begin
          n_err++; $display("FAIL sim_count c=%0d got %0d want 1", c, ifa.fifo_count);
        end
        n_cmp++;
        if (ifa.busy !== 1'b1) begin
          n_err++; $display("FAIL sim_busy c=%0d got %b want 1", c, ifa.busy);
        end
      end
      if (c == 121) begin
        n_cmp++;
        if (ifa.busy !== 1'b0) begin
          n_err++; $display("FAIL sim_idle got %b want 0", ifa.busy);
        end
      end
    end
    vld = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int bad;
    do_reset();
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      vld  = (c <= 2);
      data = (c == 0) ? 8'h00 : (c == 1) ? 8'h11 : 8'h22;
      @(posedge clk);
      #1;
    end
    vld = 1'b0;
    n_cmp++;
    if (ifa.tx !== 1'b0 || ifa.busy !== 1'b1 || ifa.fifo_count !== 3'd2) begin
      n_err++; $display("FAIL mid_pre got tx=%b busy=%b cnt=%0d want 0/1/2", ifa.tx, ifa.busy, ifa.fifo_count);
    end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ifa.tx !== 1'b1) begin
      n_err++; $display("FAIL mid_tx got %b want 1", ifa.tx);
    end
    n_cmp++;
    if (ifa.busy !== 1'b0) begin
      n_err++; $display("FAIL mid_busy got %b want 0", ifa.busy);
    end
    n_cmp++;
    if (ifa.fifo_count !== 3'd0 || ifa.tx_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_fifo got cnt=%0d rdy=%b want 0/1", ifa.fifo_count, ifa.tx_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (ifa.tx !== 1'b1 || ifa.busy !== 1'b0) begin
        n_err++; $display("FAIL mid_quiet c=%0d got tx=%b busy=%b want 1/0", c, ifa.tx, ifa.busy);
      end
    end
    n_cmp++;
    if (ifa.fifo_count !== 3'd0) begin
      n_err++; $display("FAIL mid_count_after got %0d want 0", ifa.fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_simul_push_pop();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART serialiser with an internal transmit FIFO.
- Accepts data words over a valid/ready handshake, buffers them, and sends each as an asynchronous serial frame on `tx`.
- Generates its own bit timing from `clk`. Data width, parity and stop-bit count are configurable.
- Sits between the host/command logic and the UART pad, and is paired with the UART receiver.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit (clk_freq / baud); legal range is 2 or more.
- DATA_BITS, 8: data bits per frame; legal range is 5 to 9.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits; 1 or 2.
- FIFO_DEPTH, 4: transmit FIFO entries; must be a power of 2, 2 or more.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- tx_data, input, DATA_BITS: word to transmit.
- tx_valid, input, 1: tx_data is valid.
- tx_ready, output, 1: FIFO can accept a word.
- tx, output, 1: serial line, idle high.
- busy, output, 1: a frame is in progress (FSM not in IDLE).
- fifo_count, output, $clog2(FIFO_DEPTH+1): number of occupied FIFO entries.

Behaviour:
- Reset, asynchronous: tx=1, busy=0, fifo_count=0, tx_ready=1. FSM goes to IDLE, baud and bit counters are zeroed, FIFO is emptied. Reset mid-frame aborts the frame immediately: tx goes high in the same cycle and any partial word is discarded.
- tx_ready = (fifo_count != FIFO_DEPTH). It is derived from registered state only and has no combinational path from tx_valid.
- Push: occurs on a rising edge with tx_valid && tx_ready. While tx_valid && !tx_ready, the word is not taken and the producer holds it.
- A pop in the same cycle does not raise tx_ready in that cycle. Simultaneous push and pop leaves fifo_count unchanged.
- All outputs are registered. tx must be glitch-free.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If the FIFO is non-empty, pop the head into a shift register and go to START; tx=0 is driven from the same edge.
  - Latency: a word pushed into an empty, idle block at edge N gives tx=0 starting at edge N+1.
- Bit timing: each state holds its bit for exactly CLKS_PER_BIT cycles, counted by a baud counter running 0..CLKS_PER_BIT-1. Transitions happen when the counter reaches its terminal count.
- START: tx=0 for one bit period, then go to DATA.
- DATA:
  - DATA_BITS bits, LSB first; bit index runs 0..DATA_BITS-1 with no extra iteration.
  - After the last bit, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: tx = XOR-reduce(word) ^ PARITY_ODD, for one bit period.
- STOP:
  - tx=1 for STOP_BITS bit periods.
  - At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap (back-to-back frames). Otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles exactly.
- busy=1 from the edge that enters START until the edge that returns to IDLE. During back-to-back frames busy stays 1 throughout.
- tx_data changes after a push never affect a queued or in-flight word.
- FIFO wraps using pointer arithmetic modulo FIFO_DEPTH. It never overflows (push is gated by tx_ready) and never underflows (pop only when non-empty).

Test Plan:
1. Default 8N1, CLKS_PER_BIT=4: push 0xA5 -> tx per bit is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. Frame is 40 cycles. tx=0 at the edge after the push. busy falls after cycle 40.
2. PARITY_EN=1: PARITY_ODD=0 with 0x07 -> parity bit 1; PARITY_ODD=1 with 0x07 -> parity bit 0. PARITY_ODD=0 with 0x00 -> parity bit 0. Frame is 11 bit periods.
3. FIFO_DEPTH=4: push 5 words on consecutive cycles while idle -> the first pop frees a slot, so all 5 are accepted, with at most 1 cycle of tx_ready=0. Push 6 words with tx_valid held -> the 6th stalls (tx_ready=0) until the first frame completes. Frames are contiguous with no idle-high gap beyond the stop bits.
4. STOP_BITS=2, DATA_BITS=7: push 0x55 -> 7 data bits 1,0,1,0,1,0,1, then 2 stop periods. Frame = 10 × CLKS_PER_BIT cycles.
5. Assert rst during DATA bit 3 with 2 words queued -> tx=1, busy=0, fifo_count=0 immediately. After release, nothing is transmitted until a new push.
6. Simultaneous push and pop (STOP ending, one word queued, new push) -> fifo_count unchanged, and the word order is preserved on the line.
